// File: rtl/frame_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// frame_buffer: double-buffered RGB565 store in front of a HUB75 scan engine.
// Raster pixels fill the back bank; the display bank is served as upper/lower row pairs.
module frame_buffer #(
  parameter int MATRIX_HEIGHT = 64,
  parameter int MATRIX_WIDTH  = 64,
  localparam int DEPTH = MATRIX_WIDTH * MATRIX_HEIGHT / 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [15:0]   wr_data,
  input  logic          wr_sof,
  input  logic [AW-1:0] r_addr,
  output logic [15:0]   rgb_0,
  output logic [15:0]   rgb_1,
  output logic          go,
  output logic          display_bank
);

  localparam int XW   = $clog2(MATRIX_WIDTH);
  localparam int YW   = $clog2(MATRIX_HEIGHT);
  localparam int RW   = YW - 1;
  localparam int HALF = MATRIX_HEIGHT / 2;

  localparam logic [0:0] WR_FILL    = 1'b0;
  localparam logic [0:0] WR_PENDING = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_ready_en;
  logic          r_go;
  logic          r_bank;
  logic [15:0]   r_rgb0;
  logic [15:0]   r_rgb1;

  logic [15:0]   r_mem_up [2*DEPTH];
  logic [15:0]   r_mem_lo [2*DEPTH];

  logic          w_xfer;
  logic          w_swap;
  logic          w_last;
  logic          w_lower;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [RW-1:0] w_row;
  logic [AW-1:0] w_waddr;

  // A start-of-frame beat is always pixel (0,0), overriding the running position.
  assign w_x     = wr_sof ? '0 : r_x;
  assign w_y     = wr_sof ? '0 : r_y;
  assign w_lower = (w_y >= YW'(HALF));
  assign w_row   = RW'(w_lower ? (w_y - YW'(HALF)) : w_y);
  assign w_waddr = {w_row, w_x};
  assign w_last  = (w_x == XW'(MATRIX_WIDTH - 1)) && (w_y == YW'(MATRIX_HEIGHT - 1));
  assign w_xfer  = wr_valid & wr_ready;

  // Before the first frame there is nothing on screen to tear, so swap at once.
  assign w_swap  = (r_state == WR_PENDING) && (!r_go || (r_addr == AW'(DEPTH - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WR_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WR_FILL:    if (w_xfer && w_last) w_state_nxt = WR_PENDING;
      WR_PENDING: if (w_swap)           w_state_nxt = WR_FILL;
      default:                          w_state_nxt = WR_FILL;
    endcase
  end

  always_comb begin
    wr_ready = r_ready_en && (r_state == WR_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_ready_en <= 1'b0;
      r_go       <= 1'b0;
      r_bank     <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_swap) begin
        r_x    <= '0;
        r_y    <= '0;
        r_bank <= ~r_bank;
        r_go   <= 1'b1;
      end else if (w_xfer) begin
        if (w_x == XW'(MATRIX_WIDTH - 1)) begin
          r_x <= '0;
          r_y <= (w_y == YW'(MATRIX_HEIGHT - 1)) ? '0 : w_y + 1'b1;
        end else begin
          r_x <= w_x + 1'b1;
          r_y <= w_y;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      if (w_lower) begin
        r_mem_lo[{~r_bank, w_waddr}] <= wr_data;
      end else begin
        r_mem_up[{~r_bank, w_waddr}] <= wr_data;
      end
    end
  end

  // r_bank is still the old bank on the swap edge, so the engine's frame is never split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb0 <= '0;
      r_rgb1 <= '0;
    end else begin
      r_rgb0 <= r_mem_up[{r_bank, r_addr}];
      r_rgb1 <= r_mem_lo[{r_bank, r_addr}];
    end
  end

  assign rgb_0        = r_rgb0;
  assign rgb_1        = r_rgb1;
  assign go           = r_go;
  assign display_bank = r_bank;

endmodule
`default_nettype wire

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered RGB565 frame store directly upstream of the HUB75 scan engine.
- Accepts pixels in raster order over a valid/ready stream into a back bank.
- Serves the display bank to the scan engine as interleaved pairs: `rgb_0` = upper-half row, `rgb_1` = lower-half row, addressed by the engine's `r_addr`.
- Asserts `go` once the first complete frame is displayable.

Parameters:
- MATRIX_HEIGHT, 64, panel rows (even; MATRIX_HEIGHT/2 ≤ 32).
- MATRIX_WIDTH, 64, panel columns (power of two).
- Derived: DEPTH = MATRIX_WIDTH*MATRIX_HEIGHT/2; AW = clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  pixel write valid.
- wr_ready  out  1  pixel write ready.
- wr_data  in  16  RGB565 pixel.
- wr_sof  in  1  qualifies current beat as pixel (0,0) of a new frame.
- r_addr  in  AW  read address from scan engine.
- rgb_0  out  16  display-bank pixel, upper half, at r_addr.
- rgb_1  out  16  display-bank pixel, lower half, at r_addr.
- go  out  1  level: high once first frame swapped in; stays high until reset.
- display_bank  out  1  index of bank currently displayed.

Behaviour:
- Storage: 2 banks × 2 halves, DEPTH×16 each. RAM contents are not reset.
- Write mapping for pixel (x, y), raster order:
  - y < H/2: upper half, address y*W + x.
  - else: lower half, address (y − H/2)*W + x.
- Write transfer: occurs when wr_valid & wr_ready. The pixel goes to bank ~display_bank.
- Writer FSM, 2 states:
  - WR_FILL:
    - wr_ready = 1.
    - Each transfer increments x; x wraps W−1→0 and increments y.
    - The transfer with x = W−1, y = H−1 completes the frame: set pending and go to WR_PENDING.
    - A transfer with wr_sof = 1 is written as (0,0), regardless of current x,y. Next pixel is (1,0), and any partial frame is discarded.
  - WR_PENDING:
    - wr_ready = 0; no writes.
    - Leaves to WR_FILL with x = y = 0 on the swap edge.
    - A wr_sof asserted here is ignored because no transfer occurs.
- Swap rules:
  - If go = 0: swap on the clock edge after entering WR_PENDING. The same edge sets go = 1.
  - If go = 1: swap on the edge where r_addr = DEPTH−1 while pending.
  - On the swap edge, the rgb registers still capture from the old bank. Reads from the next edge onward use the new bank, so the engine completes a frame from one bank with no tearing.
  - Swap = toggle display_bank, clear pending, writer back to WR_FILL.
- Read path:
  - rgb_0/rgb_1 are registered, 1-cycle latency: value at edge n+1 = display bank contents at r_addr sampled at edge n.
  - Reads are never stalled.
  - Simultaneous write to the back bank and read of the display bank never conflict (different banks).
- Reset (asynchronous, any time, including mid-frame or while pending):
  - rgb_0 = rgb_1 = 0, go = 0, display_bank = 0.
  - wr_ready = 1 from the first edge after rst deasserts.
  - Writer in WR_FILL with x = y = 0; pending = 0.
- Arithmetic:
  - x width = clog2(W), y width = clog2(H).
  - Addresses are computed without multipliers: the upper-half address is {y[low bits], x}.

Test Plan:
- Reset then 4096 pixels, value = raster index, wr_valid held high (64×64) -> wr_ready drops after pixel 4095. go = 1 and display_bank = 1 one edge later. wr_ready = 1 again the following cycle.
- After frame 1, drive r_addr = 67 -> next cycle rgb_0 = 67 (pixel x3,y1) and rgb_1 = 2115 (pixel x3,y33).
- go = 1, write full frame 2 (value 0xF800): wr_ready stays 0 while r_addr sweeps 0..2046. At r_addr = 2047, rgb still shows frame 1 (next-cycle value 2047 / 4095), display_bank toggles to 0 on that edge, and r_addr = 0 next returns 0xF800.
- Write 100 pixels, then a wr_sof beat of 0x1234, then the rest of a frame -> frame completes 4095 beats after the sof. The pixel at r_addr = 0 reads 0x1234.
- Toggle wr_valid pseudo-randomly during a frame load -> only handshaken beats are counted and the mapping matches the raster index.
- Assert rst asynchronously mid-write and while pending -> outputs immediately 0 / go = 0 / display_bank = 0. The next full load sets go again.
